eth10g_rx_checker: RTL
======================

Name: eth10g_rx_checker

Overview:
- Receive-side counterpart of the 10G test-traffic generator.
- Consumes the 64-bit AXI-Stream RX output of one 10GBASE-R MAC lane and validates test frames (magic, sequence number, payload pattern, length, MAC error flag).
- Keeps per-category 32-bit frame counters and drives two status LEDs.
- One instance per SFP lane, inside the test_eth10g hierarchy, in the lane's 156.25 MHz RX clock domain.

Parameters:
- MAGIC, 32'h5346_5031, required value of word0[63:32].
- MIN_WORDS, 8, minimum legal frame length in 64-bit beats.
- MAX_WORDS, 190, maximum legal frame length in beats.
- LED_STRETCH, 15625000, cycles the activity LED stays on after a good frame (100 ms at 156.25 MHz).

Ports:
- clk_156m  in  1  lane RX clock; all logic on rising edge.
- sys_reset  in  1  synchronous, active-high reset, already synchronised to clk_156m.
- s_axis_tdata  in  64  RX data, byte 0 in [7:0].
- s_axis_tkeep  in  8  byte enables.
- s_axis_tvalid  in  1  beat valid. The MAC applies no backpressure, so there is no tready.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  MAC error flag (bad FCS/PCS error), meaningful on the tlast beat only.
- cnt_clear  in  1  single-cycle pulse; zeroes all counters, clears the sticky error and clears sequence lock.
- good_cnt, seq_err_cnt, data_err_cnt, len_err_cnt, fcs_err_cnt, foreign_cnt  out  32 each  saturating frame counters.
- sleds  out  2  [0] activity (stretched good-frame indication), [1] sticky error.

Behaviour:
- Reset values: all counters 0, sleds 2'b00, state SYNC, seq_locked 0, exp_seq 0.
- States:
  - SYNC: ignore beats until a tvalid&tlast beat, then go to IDLE. Entered from reset because a reset can land mid-frame.
  - IDLE: the first tvalid beat is the header.
    - If word0[63:32] != MAGIC, flag foreign.
    - Capture seq = word0[31:0] and set beat_cnt = 1.
    - If the header beat also carries tlast, evaluate the frame immediately and stay in IDLE; otherwise go to BODY.
  - BODY: each tvalid beat k (k = beat_cnt, starting at 1) must equal {k[31:0], seq}.
    - A mismatch sets data_err; the remaining beats are still consumed but no longer compared.
    - beat_cnt is 16-bit and saturates at 16'hFFFF.
    - On tlast, evaluate and return to IDLE.
- Length rule, evaluated at tlast:
  - len_err if the final beat count (including the header beat) is < MIN_WORDS or > MAX_WORDS.
  - len_err also if tkeep on the tlast beat != 8'hFF.
  - On any non-last beat, tkeep != 8'hFF also sets len_err.
- Sequence rule:
  - If seq_locked and seq != exp_seq, flag seq_err.
  - At every frame end with no foreign flag: exp_seq <= seq + 1 (mod 2^32) and seq_locked <= 1, whatever the seq result.
  - Foreign frames do not touch exp_seq or seq_locked.
- Classification: exactly one counter increments per frame, one cycle after the tlast beat. Priority: fcs (tuser) > len > foreign > data > seq > good.
- Counter rules:
  - All counters saturate at 32'hFFFF_FFFF.
  - cnt_clear in the same cycle as an increment: clear wins and the increment is lost.
- sleds[0]:
  - Reload a down-counter to LED_STRETCH on each good classification; the LED is on while the counter is nonzero.
- sleds[1]:
  - Set on any non-good classification.
  - Cleared only by cnt_clear or reset.
- Beats with tvalid = 0 are ignored in every state. Gaps inside a frame are legal.
- A reset mid-frame returns to SYNC and produces no classification for the interrupted frame.

Decomposition:
- Package eth10g_test_pkg holds:
  - MAGIC_DEFAULT.
  - Enum chk_state_t {SYNC, IDLE, BODY}.
  - Enum frame_class_t {CLS_GOOD, CLS_SEQ, CLS_DATA, CLS_LEN, CLS_FCS, CLS_FOREIGN}.
  - Function pattern_word(k, seq).
  - The generator side imports the same package so both ends share one frame-format definition.
- Sub-module sat_counter32 (increment, clear, 32-bit saturating), instantiated six times.

Test Plan:
- Reset, then stream frames seq 0..9, 16 beats each, correct pattern -> good_cnt = 10, other counters 0, sleds = 2'b01.
- Seq 0,1,2 then jump to 7, then 8 -> seq_err_cnt = 1, good_cnt = 4 (the frame after the jump resyncs to exp 8), sleds[1] = 1.
- Frame seq 3 with beat 5 corrupted to 64'h0 and tuser = 0 -> data_err_cnt = 1. Same frame with tuser = 1 on tlast -> fcs_err_cnt = 1 and data_err_cnt unchanged.
- 4-beat frame; 191-beat frame; 16-beat frame with last tkeep = 8'h0F -> len_err_cnt = 3.
- Header magic 32'hDEAD_BEEF between seq 4 and seq 5 -> foreign_cnt = 1, no seq_err, good_cnt increments for seq 5. Then assert cnt_clear on the same cycle as a good classification -> all counters 0, sleds[1] = 0.
- Assert sys_reset at beat 6 of a 16-beat frame and deassert it -> remainder of that frame ignored (SYNC), next full frame with any seq counted good, since the sequence is unlocked after reset.

Source files
------------

// File: rtl/eth10g_rx_checker_pkg.sv
// Shared frame-format definitions for the 10G test-traffic generator and checker.
// Both ends import this package, so they always agree on the header magic,
// the body pattern and the classification codes.
package eth10g_test_pkg;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h5346_5031;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    BODY
  } chk_state_t;

  typedef enum logic [2:0] {
    CLS_GOOD,
    CLS_SEQ,
    CLS_DATA,
    CLS_LEN,
    CLS_FCS,
    CLS_FOREIGN
  } frame_class_t;

  localparam int NUM_CLASSES = 6;

  // Body beat k of a frame carrying sequence number seq.
  function automatic logic [63:0] pattern_word(input logic [31:0] k, input logic [31:0] seq);
    return {k, seq};
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth10g_rx_checker_if.sv
// 64-bit AXI-Stream RX bus from one 10GBASE-R MAC lane. The MAC cannot be
// stalled, so there is no tready.
interface eth10g_rx_checker_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/eth10g_rx_checker_sat_counter32.sv
// 32-bit event counter that sticks at all-ones; clear beats a same-cycle increment.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clear,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // the flop is written with non-blocking assignments only.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/eth10g_rx_checker.sv
// Receive-side test-frame checker for one 10G lane: validates header magic,
// sequence number, body pattern, length and MAC error flag, classifies each
// frame into exactly one saturating counter and drives activity/error LEDs.
module eth10g_rx_checker
  import eth10g_test_pkg::*;
#(
  parameter logic [31:0] MAGIC       = MAGIC_DEFAULT,
  parameter int unsigned MIN_WORDS   = 8,
  parameter int unsigned MAX_WORDS   = 190,
  parameter int unsigned LED_STRETCH = 15625000
) (
  input  logic                 clk_156m,
  input  logic                 sys_reset,
  eth10g_rx_checker_if.slave   s_axis,
  input  logic                 cnt_clear,
  output logic [31:0]          good_cnt,
  output logic [31:0]          seq_err_cnt,
  output logic [31:0]          data_err_cnt,
  output logic [31:0]          len_err_cnt,
  output logic [31:0]          fcs_err_cnt,
  output logic [31:0]          foreign_cnt,
  output logic [1:0]           sleds
);

  localparam int LED_W = $clog2(LED_STRETCH + 1);
  localparam logic [LED_W-1:0] LED_RELOAD = LED_W'(LED_STRETCH);

  chk_state_t        state_q, state_d;
  logic [31:0]       seq_q, seq_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic              data_err_q, data_err_d;
  logic              len_err_q, len_err_d;
  logic              foreign_q, foreign_d;
  logic [31:0]       exp_seq_q, exp_seq_d;
  logic              seq_locked_q, seq_locked_d;
  logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
  logic              sticky_q, sticky_d;

  // Per-frame verdict inputs, valid while frame_end is high.
  logic              frame_end;
  logic [31:0]       f_seq;
  logic [15:0]       f_words;
  logic              f_data, f_len, f_foreign;
  logic              keep_bad;
  logic              len_bad, seq_bad;
  frame_class_t      cls;
  logic [NUM_CLASSES-1:0] cls_inc;
  logic [31:0]       cnt [NUM_CLASSES];

  assign keep_bad = (s_axis.tkeep != 8'hFF);

  // Frame parser: walks SYNC/IDLE/BODY and accumulates the per-frame error flags.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    beat_cnt_d = beat_cnt_q;
    data_err_d = data_err_q;
    len_err_d  = len_err_q;
    foreign_d  = foreign_q;
    frame_end  = 1'b0;
    f_seq      = seq_q;
    f_words    = sat_inc16(beat_cnt_q);
    f_data     = data_err_q;
    f_len      = len_err_q;
    f_foreign  = foreign_q;
    unique case (state_q)
      SYNC: begin
        // A reset can land mid-frame, so wait for a frame boundary first.
        if (s_axis.tvalid && s_axis.tlast) state_d = IDLE;
      end
      IDLE: begin
        if (s_axis.tvalid) begin
          seq_d      = s_axis.tdata[31:0];
          beat_cnt_d = 16'd1;
          data_err_d = 1'b0;
          foreign_d  = (s_axis.tdata[63:32] != MAGIC);
          len_err_d  = keep_bad;
          if (s_axis.tlast) begin
            frame_end = 1'b1;
            f_seq     = s_axis.tdata[31:0];
            f_words   = 16'd1;
            f_data    = 1'b0;
            f_len     = len_err_d;
            f_foreign = foreign_d;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (s_axis.tvalid) begin
          // After the first mismatch the rest of the body is only consumed.
          if (!data_err_q &&
              (s_axis.tdata != pattern_word({16'h0000, beat_cnt_q}, seq_q))) begin
            data_err_d = 1'b1;
          end
          len_err_d  = len_err_q | keep_bad;
          beat_cnt_d = sat_inc16(beat_cnt_q);
          if (s_axis.tlast) begin
            frame_end = 1'b1;
            f_data    = data_err_d;
            f_len     = len_err_d;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Frame classification by priority, and sequence tracking at frame end.
  always_comb begin
    exp_seq_d    = exp_seq_q;
    seq_locked_d = seq_locked_q;
    cls_inc      = '0;
    len_bad      = f_len || (32'(f_words) < MIN_WORDS) || (32'(f_words) > MAX_WORDS);
    seq_bad      = seq_locked_q && (f_seq != exp_seq_q);
    if (s_axis.tuser)  cls = CLS_FCS;
    else if (len_bad)  cls = CLS_LEN;
    else if (f_foreign) cls = CLS_FOREIGN;
    else if (f_data)   cls = CLS_DATA;
    else if (seq_bad)  cls = CLS_SEQ;
    else               cls = CLS_GOOD;
    if (frame_end) begin
      cls_inc[cls] = 1'b1;
      // Resync to whatever sequence we saw, so one jump costs one error.
      if (!f_foreign) begin
        exp_seq_d    = f_seq + 32'd1;
        seq_locked_d = 1'b1;
      end
    end
    if (cnt_clear) seq_locked_d = 1'b0;
  end

  // Status LEDs: stretched good-frame activity and sticky error.
  always_comb begin
    led_cnt_d = led_cnt_q;
    sticky_d  = sticky_q;
    if (led_cnt_q != '0) led_cnt_d = led_cnt_q - LED_W'(1);
    if (cls_inc[CLS_GOOD]) led_cnt_d = LED_RELOAD;
    if (frame_end && (cls != CLS_GOOD)) sticky_d = 1'b1;
    if (cnt_clear) sticky_d = 1'b0;
  end

  // State and tracking registers.
  always_ff @(posedge clk_156m) begin
    if (sys_reset) begin
      state_q      <= SYNC;
      seq_q        <= '0;
      beat_cnt_q   <= '0;
      data_err_q   <= 1'b0;
      len_err_q    <= 1'b0;
      foreign_q    <= 1'b0;
      exp_seq_q    <= '0;
      seq_locked_q <= 1'b0;
      led_cnt_q    <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      beat_cnt_q   <= beat_cnt_d;
      data_err_q   <= data_err_d;
      len_err_q    <= len_err_d;
      foreign_q    <= foreign_d;
      exp_seq_q    <= exp_seq_d;
      seq_locked_q <= seq_locked_d;
      led_cnt_q    <= led_cnt_d;
      sticky_q     <= sticky_d;
    end
  end

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
    sat_counter32 u_cnt (
      .clk   (clk_156m),
      .rst   (sys_reset),
      .inc   (cls_inc[i]),
      .clear (cnt_clear),
      .count (cnt[i])
    );
  end

  assign good_cnt     = cnt[CLS_GOOD];
  assign seq_err_cnt  = cnt[CLS_SEQ];
  assign data_err_cnt = cnt[CLS_DATA];
  assign len_err_cnt  = cnt[CLS_LEN];
  assign fcs_err_cnt  = cnt[CLS_FCS];
  assign foreign_cnt  = cnt[CLS_FOREIGN];
  assign sleds        = {sticky_q, (led_cnt_q != '0)};

endmodule
